// File: rtl/geofence_frame_feeder.sv
// Frame feeder for the geofence engine: gathers 7-point frames (test point then
// 6 fence vertices) into NBUF buffers and streams each one gap-free to the engine.
//
// state  | meaning
// HOLD   | engine held in reset, waiting for a committed frame
// STREAM | driving the 7 points of the oldest frame, one per cycle
// WAIT   | bus parked at 0, waiting for the engine result or the timeout
module geofence_frame_feeder #(
  parameter int NBUF    = 2,
  parameter int TIMEOUT = 63,
  parameter int CW      = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_x,
  input  logic [CW-1:0] in_y,
  output logic          gf_reset,
  output logic [CW-1:0] gf_x,
  output logic [CW-1:0] gf_y,
  input  logic          gf_valid,
  input  logic          gf_is_inside,
  output logic          res_valid,
  output logic          res_inside,
  output logic          res_timeout,
  output logic [7:0]    res_frame,
  output logic          busy
);

  localparam int PW = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int FW = $clog2(NBUF + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] LAST_BUF   = PW'(NBUF - 1);
  localparam logic [FW-1:0] NBUF_CNT   = FW'(NBUF);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {HOLD, STREAM, WAIT} state_t;

  state_t          state;
  logic [2*CW-1:0] mem [NBUF][7];
  logic [2:0]      fill_idx;
  logic [2:0]      rd_idx;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [FW-1:0]   full_cnt;
  logic [TW-1:0]   timer;
  logic [7:0]      frame_id;

  logic            accept;
  logic            commit;
  logic            buf_release;
  logic [2:0]      fill_next;
  logic [FW-1:0]   full_next;
  logic            held_next;
  logic [PW-1:0]   wr_ptr_inc;
  logic [PW-1:0]   rd_ptr_inc;

  always_comb begin
    accept      = in_valid && in_ready;
    commit      = accept && (fill_idx == 3'd6);
    buf_release = (state == STREAM) && (rd_idx == 3'd6);
    fill_next   = fill_idx;
    if (commit)
      fill_next = 3'd0;
    else if (accept)
      fill_next = fill_idx + 3'd1;
    // full_cnt counts committed frames including the one being streamed
    full_next = full_cnt;
    if (commit && !buf_release)
      full_next = full_cnt + FW'(1);
    else if (!commit && buf_release)
      full_next = full_cnt - FW'(1);
    held_next  = (fill_next != 3'd0) || (full_next != '0);
    wr_ptr_inc = (wr_ptr == LAST_BUF) ? '0 : wr_ptr + PW'(1);
    rd_ptr_inc = (rd_ptr == LAST_BUF) ? '0 : rd_ptr + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr][fill_idx] <= {in_x, in_y};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= HOLD;
      gf_reset    <= 1'b1;
      gf_x        <= '0;
      gf_y        <= '0;
      res_valid   <= 1'b0;
      res_inside  <= 1'b0;
      res_timeout <= 1'b0;
      res_frame   <= '0;
      frame_id    <= '0;
      fill_idx    <= '0;
      rd_idx      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      full_cnt    <= '0;
      timer       <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      fill_idx  <= fill_next;
      full_cnt  <= full_next;
      in_ready  <= (full_next < NBUF_CNT);
      res_valid <= 1'b0;
      if (commit)
        wr_ptr <= wr_ptr_inc;

      case (state)
        HOLD: begin
          if (full_cnt != '0) begin
            state        <= STREAM;
            rd_idx       <= '0;
            gf_reset     <= 1'b0;
            {gf_x, gf_y} <= mem[rd_ptr][0];
            busy         <= 1'b1;
          end else begin
            gf_reset <= 1'b1;
            gf_x     <= '0;
            gf_y     <= '0;
            busy     <= held_next;
          end
        end

        STREAM: begin
          gf_reset <= 1'b0;
          busy     <= 1'b1;
          if (rd_idx == 3'd6) begin
            state  <= WAIT;
            rd_ptr <= rd_ptr_inc;
            timer  <= TIMER_LOAD;
            gf_x   <= '0;
            gf_y   <= '0;
          end else begin
            rd_idx       <= rd_idx + 3'd1;
            {gf_x, gf_y} <= mem[rd_ptr][rd_idx + 3'd1];
          end
        end

        WAIT: begin
          if (gf_valid) begin
            res_valid   <= 1'b1;
            res_inside  <= gf_is_inside;
            res_timeout <= 1'b0;
            res_frame   <= frame_id;
            frame_id    <= frame_id + 8'd1;
            // a frame committed on this same edge is not seen until HOLD
            if (full_cnt != '0) begin
              state        <= STREAM;
              rd_idx       <= '0;
              gf_reset     <= 1'b0;
              {gf_x, gf_y} <= mem[rd_ptr][0];
              busy         <= 1'b1;
            end else begin
              state    <= HOLD;
              gf_reset <= 1'b1;
              busy     <= held_next;
            end
          end else if (timer == '0) begin
            res_valid   <= 1'b1;
            res_inside  <= 1'b0;
            res_timeout <= 1'b1;
            res_frame   <= frame_id;
            frame_id    <= frame_id + 8'd1;
            state       <= HOLD;
            gf_reset    <= 1'b1;
            busy        <= held_next;
          end else begin
            timer <= timer - TW'(1);
            busy  <= 1'b1;
          end
        end

        default: begin
          state    <= HOLD;
          gf_reset <= 1'b1;
          gf_x     <= '0;
          gf_y     <= '0;
          busy     <= held_next;
        end
      endcase
    end
  end

endmodule

// File: doc/geofence_frame_feeder.md
Name: geofence_frame_feeder

Overview:
- Upstream stage of the geofence engine.
- Collects (x,y) points from a valid/ready source into whole 7-point frames: test point first, then 6 fence vertices. Buffers up to NBUF frames.
- Streams each frame gap-free into the engine's X/Y bus and gates the engine through its active-high reset.
- Returns one result per frame (inside flag, frame number, timeout flag).

Parameters:
- NBUF, 2: number of whole-frame buffers (≥2).
- TIMEOUT, 63: max WAIT cycles for the engine's valid before abort.
- CW, 10: coordinate width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  upstream point valid
- in_ready  out  1  upstream point accept
- in_x  in  CW  point x
- in_y  in  CW  point y
- gf_reset  out  1  active-high reset to the geofence engine
- gf_x  out  CW  X to the engine
- gf_y  out  CW  Y to the engine
- gf_valid  in  1  engine result strobe
- gf_is_inside  in  1  engine inside flag
- res_valid  out  1  one-cycle result pulse
- res_inside  out  1  inside flag, qualified by res_valid
- res_timeout  out  1  frame aborted, qualified by res_valid
- res_frame  out  8  frame sequence number, qualified by res_valid
- busy  out  1  any partial/full frame held, or state≠HOLD

Behaviour:
- All outputs registered. Clock: one clock, clk. Reset: synchronous, active-low.
- Reset (reset==0 at an edge) forces the following, regardless of state:
  - state HOLD, gf_reset=1, gf_x=gf_y=0
  - res_valid=res_inside=res_timeout=0, res_frame counter=0
  - all buffers empty, partial frame discarded, in_ready=1, busy=0
- Input side:
  - A point is accepted when in_valid&&in_ready. Fill index 0..6 (0 = test point).
  - Accepting index 6 commits the frame (full count +1) and resets the fill index to 0.
  - in_ready = 0 when all NBUF buffers are committed or streaming; otherwise 1. Bubbles in in_valid are allowed.
- Output FSM has three states: HOLD, STREAM, WAIT.
- HOLD:
  - gf_reset=1, gf_x/gf_y=0.
  - If full count>0 at an edge, go to STREAM with idx=0, oldest frame first.
- STREAM:
  - gf_reset=0, {gf_x,gf_y}=buffer[rd][idx], idx increments every cycle with no stall.
  - After idx 6, go to WAIT. The buffer is released on that edge.
  - The result is exactly 7 consecutive cycles: test point, then fence 0..5. This matches the engine capturing the test point in its IDLE cycle and the fences in the next 6 cycles.
- WAIT:
  - gf_reset=0, gf_x/gf_y=0. Cycle timer starts at 1 and increments.
  - gf_valid=1:
    - Next cycle: res_valid=1, res_inside=gf_is_inside, res_timeout=0, res_frame=current id. Id then increments and wraps at 255→0.
    - Next state is STREAM idx 0 if full count>0, otherwise HOLD.
    - The back-to-back case puts the next test point on the bus in the engine's IDLE cycle, the cycle right after its valid.
  - timer==TIMEOUT && !gf_valid:
    - Next cycle: res_valid=1, res_timeout=1, res_inside=0. Id increments.
    - Go to HOLD unconditionally, so gf_reset=1 for ≥1 cycle to restart the engine.
- gf_valid outside WAIT is ignored.
- Simultaneous commit and release on one edge: full count unchanged. A frame committed on the WAIT-exit edge is not visible until the next edge, so the FSM goes to HOLD for one cycle.
- Latency:
  - Commit of 7th point → test point on gf bus 1 cycle later, when in HOLD.
  - gf_valid → res_valid 1 cycle.
- Reset mid-stream or mid-wait: abort immediately as above; no result is emitted for the aborted frame.

Test Plan:
- Reset, then feed T=(5,5) and hexagon (10,0),(20,0),(25,10),(20,20),(10,20),(5,10) with no gaps → 1 cycle after 7th accept: gf_reset=0, gf_x/y=(5,5); then 6 fences in order on consecutive cycles. Engine model returns gf_valid, inside=1 → next cycle res_valid=1, res_inside=1, res_frame=0.
- Feed 14 points (NBUF=2), engine replies valid 10 cycles after stream end → frame 1 test point on gf bus the cycle after gf_valid, gf_reset never rises; res_frame 0 then 1.
- Hold gf_valid low while feeding 21 points → frame 0 streams; frames 1,2 buffer; in_ready=0 after 21st accept. in_ready returns to 1 the cycle after frame 1 finishes streaming.
- gf_valid never asserted → exactly 63 WAIT cycles, then res_valid=1, res_timeout=1, res_inside=0. Next cycle gf_reset=1.
- Pull reset low during STREAM idx 3 → next cycle gf_reset=1, gf_x/y=0, in_ready=1, busy=0, no res_valid. Next frame reports res_frame=0.
- Random in_valid bubbles (50%) within a frame → gf stream still 7 contiguous cycles with correct order; results match golden engine model.
